// File: rtl/tm_qm_ctrl_pkg.sv
// tm_qm_ctrl_pkg: scheduler descriptor type and default queue sizing shared by the queue manager
`ifndef FOURTH_LVL_QUEUE_ID_NBITS
`define FOURTH_LVL_QUEUE_ID_NBITS 4
`endif
package meta_package;
   typedef struct packed {
      logic [3:0]  port;
      logic [11:0] len;
   } sch_pkt_desc_type;
endpackage

// File: rtl/tm_qm_ctrl_if.sv
// tm_qm_ctrl_if: enqueue/dequeue request-response bundle between a client and the queue manager
interface tm_qm_ctrl_if #(parameter int QUEUE_ID_NBITS = `FOURTH_LVL_QUEUE_ID_NBITS);
   import meta_package::*;
   logic                      enq_req;
   logic [QUEUE_ID_NBITS-1:0] enq_qid;
   sch_pkt_desc_type          enq_desc;
   logic                      enq_ack;
   logic                      enq_drop;
   logic                      deq_req;
   logic [QUEUE_ID_NBITS-1:0] deq_qid;
   logic                      deq_valid;
   logic                      deq_empty;
   sch_pkt_desc_type          deq_desc;
   modport master (output enq_req, enq_qid, enq_desc, deq_req, deq_qid,
                   input enq_ack, enq_drop, deq_valid, deq_empty, deq_desc);
   modport slave (input enq_req, enq_qid, enq_desc, deq_req, deq_qid,
                  output enq_ack, enq_drop, deq_valid, deq_empty, deq_desc);
endinterface

// File: rtl/tm_qm_ctrl.sv
// tm_qm_ctrl: linked-list queue manager over external 1R1W head/tail/depth/ll/pkt_desc memories with a free list
module tm_qm_ctrl
   import meta_package::*;
#(
   parameter int QUEUE_ID_NBITS      = `FOURTH_LVL_QUEUE_ID_NBITS,
   parameter int QUEUE_ENTRIES_NBITS = `FOURTH_LVL_QUEUE_ID_NBITS
) (
   input  logic                           clk,
   input  logic                           rst,
   tm_qm_ctrl_if.slave                    q,
   output logic                           init_done,
   output logic                           head_wr,
   output logic [QUEUE_ID_NBITS-1:0]      head_raddr,
   output logic [QUEUE_ID_NBITS-1:0]      head_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] head_wdata,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] head_rdata,
   output logic                           tail_wr,
   output logic [QUEUE_ID_NBITS-1:0]      tail_raddr,
   output logic [QUEUE_ID_NBITS-1:0]      tail_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] tail_wdata,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] tail_rdata,
   output logic                           depth_wr,
   output logic [QUEUE_ID_NBITS-1:0]      depth_raddr,
   output logic [QUEUE_ID_NBITS-1:0]      depth_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] depth_wdata,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] depth_rdata,
   output logic                           depth1_wr,
   output logic [QUEUE_ID_NBITS-1:0]      depth1_raddr,
   output logic [QUEUE_ID_NBITS-1:0]      depth1_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] depth1_wdata,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] depth1_rdata,
   output logic                           ll_wr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] ll_raddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] ll_waddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] ll_wdata,
   input  logic [QUEUE_ENTRIES_NBITS-1:0] ll_rdata,
   output logic                           pkt_desc_wr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_raddr,
   output logic [QUEUE_ENTRIES_NBITS-1:0] pkt_desc_waddr,
   output sch_pkt_desc_type               pkt_desc_wdata,
   input  sch_pkt_desc_type               pkt_desc_rdata
);
   localparam int N = QUEUE_ENTRIES_NBITS;
   localparam logic [N-1:0] FL_HEAD_RST = '0;
   localparam logic [N-1:0] FL_TAIL_RST = N'(2**N - 2);
   localparam logic [N:0]   FL_CNT_RST  = (N+1)'(2**N - 1);
   typedef enum logic [2:0] {INIT, IDLE, E0, E1, D0, D1, D2} state_t;
   state_t       state, nxt;
   logic [N-1:0] cnt, fl_head, fl_tail, buf_idx;
   logic [N:0]   fl_cnt;
   logic         last_enq, pick_enq, fl_empty, dep_zero;
   logic         unused_depth1;
   assign unused_depth1 = ^depth1_rdata;
   assign fl_empty = fl_cnt == '0;
   assign dep_zero = depth_rdata == '0;
   assign pick_enq = q.enq_req & (~q.deq_req | ~last_enq);
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= INIT;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         INIT:    nxt = cnt == '1 ? IDLE : INIT;
         IDLE:    nxt = pick_enq ? E0 : q.deq_req ? D0 : IDLE;
         E0:      nxt = fl_empty ? IDLE : E1;
         D0:      nxt = D1;
         D1:      nxt = dep_zero ? IDLE : D2;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt       <= '0;
         init_done <= 1'b0;
         fl_head   <= FL_HEAD_RST;
         fl_tail   <= FL_TAIL_RST;
         fl_cnt    <= FL_CNT_RST;
         buf_idx   <= '0;
         last_enq  <= 1'b0;
      end else begin
         if (state == INIT) begin
            cnt       <= cnt + 1'b1;
            init_done <= cnt == '1;
         end
         if (state == IDLE && nxt != IDLE) last_enq <= nxt == E0;
         if (state == E0) buf_idx <= fl_head;
         if (state == D1) buf_idx <= head_rdata;
         if (state == E1) begin
            fl_head <= ll_rdata;
            fl_cnt  <= fl_cnt - 1'b1;
         end
         // a freed buffer restarts an exhausted list instead of being linked
         if (state == D2) begin
            if (fl_empty) fl_head <= buf_idx;
            fl_tail <= buf_idx;
            fl_cnt  <= fl_cnt + 1'b1;
         end
      end
   // outputs are forced low while reset is held, even though state sits in INIT
   always_comb begin
      {head_wr, tail_wr, depth_wr, ll_wr, pkt_desc_wr} = '0;
      {head_raddr, head_waddr, head_wdata} = '0;
      {tail_raddr, tail_waddr, tail_wdata} = '0;
      {depth_raddr, depth_waddr, depth_wdata} = '0;
      {ll_raddr, ll_waddr, ll_wdata} = '0;
      {pkt_desc_raddr, pkt_desc_waddr} = '0;
      pkt_desc_wdata = '0;
      {q.enq_ack, q.enq_drop, q.deq_valid, q.deq_empty} = '0;
      q.deq_desc = '0;
      if (!rst)
         case (state)
            INIT: begin
               ll_wr    = 1'b1;
               ll_waddr = cnt;
               ll_wdata = cnt + 1'b1;
               if ((cnt >> QUEUE_ID_NBITS) == '0) begin
                  {head_wr, tail_wr, depth_wr} = '1;
                  head_waddr  = cnt[QUEUE_ID_NBITS-1:0];
                  tail_waddr  = cnt[QUEUE_ID_NBITS-1:0];
                  depth_waddr = cnt[QUEUE_ID_NBITS-1:0];
               end
            end
            E0: begin
               q.enq_drop  = fl_empty;
               tail_raddr  = q.enq_qid;
               depth_raddr = q.enq_qid;
               ll_raddr    = fl_head;
            end
            E1: begin
               q.enq_ack      = 1'b1;
               pkt_desc_wr    = 1'b1;
               pkt_desc_waddr = buf_idx;
               pkt_desc_wdata = q.enq_desc;
               head_wr        = dep_zero;
               head_waddr     = q.enq_qid;
               head_wdata     = buf_idx;
               ll_wr          = !dep_zero;
               ll_waddr       = tail_rdata;
               ll_wdata       = buf_idx;
               tail_wr        = 1'b1;
               tail_waddr     = q.enq_qid;
               tail_wdata     = buf_idx;
               depth_wr       = 1'b1;
               depth_waddr    = q.enq_qid;
               depth_wdata    = depth_rdata + 1'b1;
            end
            D0: begin
               head_raddr  = q.deq_qid;
               depth_raddr = q.deq_qid;
            end
            D1: begin
               q.deq_empty    = dep_zero;
               ll_raddr       = head_rdata;
               pkt_desc_raddr = head_rdata;
               depth_raddr    = q.deq_qid;
            end
            D2: begin
               q.deq_valid = 1'b1;
               q.deq_desc  = pkt_desc_rdata;
               head_wr     = 1'b1;
               head_waddr  = q.deq_qid;
               head_wdata  = ll_rdata;
               depth_wr    = 1'b1;
               depth_waddr = q.deq_qid;
               depth_wdata = depth_rdata - 1'b1;
               ll_wr       = !fl_empty;
               ll_waddr    = fl_tail;
               ll_wdata    = buf_idx;
            end
            default: ;
         endcase
   end
   assign depth1_wr    = depth_wr;
   assign depth1_raddr = depth_raddr;
   assign depth1_waddr = depth_waddr;
   assign depth1_wdata = depth_wdata;
endmodule

// File: tb/tb_tm_qm_ctrl.sv
// tb_tm_qm_ctrl: directed vectors for tm_qm_ctrl with behavioural 1R1W queue memories
module tb_tm_qm_ctrl;
   import meta_package::*;
   localparam int R_ACK = 0, R_DROP = 1, R_VALID = 2, R_EMPTY = 3, R_NONE = 4;
   localparam int NV = 26;
   typedef struct {
      bit          is_enq;
      logic [1:0]  qid;
      logic [15:0] desc;
      int          res;
      int          lat;
      int          exp_buf;
   } vec_t;
   logic clk, rst, init_done;
   logic head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr;
   logic [1:0] head_raddr, head_waddr, tail_raddr, tail_waddr;
   logic [1:0] depth_raddr, depth_waddr, depth1_raddr, depth1_waddr;
   logic [2:0] head_wdata, head_rdata, tail_wdata, tail_rdata;
   logic [2:0] depth_wdata, depth_rdata, depth1_wdata, depth1_rdata;
   logic [2:0] ll_raddr, ll_waddr, ll_wdata, ll_rdata, pkt_desc_raddr, pkt_desc_waddr;
   sch_pkt_desc_type pkt_desc_wdata, pkt_desc_rdata;
   logic [2:0] head_m [4], tail_m [4], depth_m [4], depth1_m [4], ll_m [8];
   sch_pkt_desc_type pd_m [8];
   int total = 0, bad = 0;
   tm_qm_ctrl_if #(.QUEUE_ID_NBITS(2)) bus ();
   tm_qm_ctrl #(.QUEUE_ID_NBITS(2), .QUEUE_ENTRIES_NBITS(3)) dut (
      .clk(clk), .rst(rst), .q(bus), .init_done(init_done),
      .head_wr(head_wr), .head_raddr(head_raddr), .head_waddr(head_waddr), .head_wdata(head_wdata), .head_rdata(head_rdata),
      .tail_wr(tail_wr), .tail_raddr(tail_raddr), .tail_waddr(tail_waddr), .tail_wdata(tail_wdata), .tail_rdata(tail_rdata),
      .depth_wr(depth_wr), .depth_raddr(depth_raddr), .depth_waddr(depth_waddr), .depth_wdata(depth_wdata), .depth_rdata(depth_rdata),
      .depth1_wr(depth1_wr), .depth1_raddr(depth1_raddr), .depth1_waddr(depth1_waddr), .depth1_wdata(depth1_wdata), .depth1_rdata(depth1_rdata),
      .ll_wr(ll_wr), .ll_raddr(ll_raddr), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata), .ll_rdata(ll_rdata),
      .pkt_desc_wr(pkt_desc_wr), .pkt_desc_raddr(pkt_desc_raddr), .pkt_desc_waddr(pkt_desc_waddr),
      .pkt_desc_wdata(pkt_desc_wdata), .pkt_desc_rdata(pkt_desc_rdata)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (head_wr) head_m[head_waddr] <= head_wdata;
      if (tail_wr) tail_m[tail_waddr] <= tail_wdata;
      if (depth_wr) depth_m[depth_waddr] <= depth_wdata;
      if (depth1_wr) depth1_m[depth1_waddr] <= depth1_wdata;
      if (ll_wr) ll_m[ll_waddr] <= ll_wdata;
      if (pkt_desc_wr) pd_m[pkt_desc_waddr] <= pkt_desc_wdata;
      head_rdata     <= head_m[head_raddr];
      tail_rdata     <= tail_m[tail_raddr];
      depth_rdata    <= depth_m[depth_raddr];
      depth1_rdata   <= depth1_m[depth1_raddr];
      ll_rdata       <= ll_m[ll_raddr];
      pkt_desc_rdata <= pd_m[pkt_desc_raddr];
   end
   function automatic logic pulses();
      return bus.enq_ack | bus.enq_drop | bus.deq_valid | bus.deq_empty;
   endfunction
   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic wait_init(output int n, output logic seen);
      n = 0;
      seen = 0;
      while (!init_done && n < 20) begin
         @(negedge clk);
         n++;
         seen |= pulses();
      end
   endtask
   task automatic run_op(input bit is_enq, input logic [1:0] qid, input logic [15:0] desc,
                         output int res, output int lat, output logic [15:0] gd, output int gb);
      if (is_enq) begin
         bus.enq_qid  = qid;
         bus.enq_desc = desc;
         bus.enq_req  = 1;
      end else begin
         bus.deq_qid = qid;
         bus.deq_req = 1;
      end
      res = R_NONE;
      lat = 0;
      gd  = '0;
      gb  = -1;
      while (res == R_NONE && lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.enq_ack) begin
            res = R_ACK;
            gb  = int'(pkt_desc_waddr);
         end else if (bus.enq_drop) res = R_DROP;
         else if (bus.deq_valid) begin
            res = R_VALID;
            gd  = bus.deq_desc;
         end else if (bus.deq_empty) res = R_EMPTY;
      end
      bus.enq_req = 0;
      bus.deq_req = 0;
      @(negedge clk);
   endtask
   vec_t v [NV];
   initial begin
      int res, lat, gb, n;
      logic [15:0] gd, ed;
      logic seen, seen0;
      v[0]  = '{1, 1, 16'h1111, R_ACK, 2, 0};
      v[1]  = '{1, 1, 16'h2222, R_ACK, 2, 1};
      v[2]  = '{0, 1, 16'h1111, R_VALID, 3, -1};
      v[3]  = '{0, 1, 16'h2222, R_VALID, 3, -1};
      v[4]  = '{0, 1, 16'h0000, R_EMPTY, 2, -1};
      v[5]  = '{1, 0, 16'h0001, R_ACK, 2, 2};
      v[6]  = '{1, 1, 16'h0002, R_ACK, 2, 3};
      v[7]  = '{1, 2, 16'h0003, R_ACK, 2, 4};
      v[8]  = '{1, 3, 16'h0004, R_ACK, 2, 5};
      v[9]  = '{1, 0, 16'h0005, R_ACK, 2, 6};
      v[10] = '{1, 1, 16'h0006, R_ACK, 2, 0};
      v[11] = '{1, 2, 16'h0007, R_ACK, 2, 1};
      v[12] = '{1, 3, 16'h0008, R_DROP, 1, -1};
      v[13] = '{0, 0, 16'h0001, R_VALID, 3, -1};
      v[14] = '{1, 3, 16'h0009, R_ACK, 2, 2};
      v[15] = '{0, 0, 16'h0005, R_VALID, 3, -1};
      v[16] = '{0, 1, 16'h0002, R_VALID, 3, -1};
      v[17] = '{0, 1, 16'h0006, R_VALID, 3, -1};
      v[18] = '{0, 2, 16'h0003, R_VALID, 3, -1};
      v[19] = '{0, 2, 16'h0007, R_VALID, 3, -1};
      v[20] = '{0, 3, 16'h0004, R_VALID, 3, -1};
      v[21] = '{0, 3, 16'h0009, R_VALID, 3, -1};
      v[22] = '{0, 3, 16'h0000, R_EMPTY, 2, -1};
      v[23] = '{1, 0, 16'h000A, R_ACK, 2, 6};
      v[24] = '{0, 0, 16'h000A, R_VALID, 3, -1};
      v[25] = '{0, 0, 16'h0000, R_EMPTY, 2, -1};
      rst = 1;
      bus.enq_req = 1;
      bus.enq_qid = 0;
      bus.enq_desc = 16'h00ff;
      bus.deq_req = 0;
      bus.deq_qid = 0;
      repeat (3) @(negedge clk);
      check("rst_wr", {head_wr, tail_wr, depth_wr, depth1_wr, ll_wr, pkt_desc_wr}, 0);
      check("rst_bus", int'(|{head_raddr, head_waddr, head_wdata, tail_raddr, tail_waddr, tail_wdata,
                             depth_raddr, depth_waddr, depth_wdata, depth1_raddr, depth1_waddr, depth1_wdata,
                             ll_raddr, ll_waddr, ll_wdata, pkt_desc_raddr, pkt_desc_waddr, pkt_desc_wdata}), 0);
      check("rst_pulse", {bus.enq_ack, bus.enq_drop, bus.deq_valid, bus.deq_empty, init_done, bus.deq_desc}, 0);
      rst = 0;
      wait_init(n, seen);
      bus.enq_req = 0;
      check("init_cycles", n, 8);
      check("init_no_resp", seen, 0);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         seen |= pulses();
      end
      check("init_req_ignored", seen, 0);
      for (int k = 0; k < NV; k++) begin
         run_op(v[k].is_enq, v[k].qid, v[k].desc, res, lat, gd, gb);
         check($sformatf("v%0d_res", k), res, v[k].res);
         check($sformatf("v%0d_lat", k), lat, v[k].lat);
         if (v[k].res == R_ACK) check($sformatf("v%0d_buf", k), gb, v[k].exp_buf);
         if (v[k].res == R_VALID) check($sformatf("v%0d_desc", k), gd, v[k].desc);
      end
      rst = 1;
      @(negedge clk);
      rst = 0;
      wait_init(n, seen);
      check("arb_init", n, 8);
      ed = 16'h0100;
      bus.enq_qid  = 2;
      bus.deq_qid  = 2;
      bus.enq_desc = ed;
      bus.enq_req  = 1;
      bus.deq_req  = 1;
      for (int k = 0; k < 6; k++) begin
         res = R_NONE;
         n = 0;
         while (res == R_NONE && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.enq_ack) res = R_ACK;
            else if (bus.deq_valid) begin
               res = R_VALID;
               gd  = bus.deq_desc;
            end else if (bus.enq_drop | bus.deq_empty) res = R_DROP;
         end
         check($sformatf("arb%0d_res", k), res, (k % 2) ? R_VALID : R_ACK);
         if (k % 2) check($sformatf("arb%0d_desc", k), gd, 16'h0100 + k / 2);
         if (res == R_ACK) begin
            @(negedge clk);
            ed = ed + 1;
            bus.enq_desc = ed;
         end
      end
      bus.enq_req = 0;
      bus.deq_req = 0;
      @(negedge clk);
      run_op(1, 1, 16'h0abc, res, lat, gd, gb);
      check("abort_pre_enq", res, R_ACK);
      bus.deq_qid = 1;
      bus.deq_req = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      bus.deq_req = 0;
      #1;
      check("abort_init_done", init_done, 0);
      @(negedge clk);
      seen0 = pulses();
      rst = 0;
      wait_init(n, seen);
      check("abort_no_valid", seen | seen0, 0);
      check("abort_reinit", n, 8);
      for (int k = 0; k < 4; k++) begin
         run_op(0, 2'(k), 16'h0, res, lat, gd, gb);
         check($sformatf("abort_q%0d_empty", k), res, R_EMPTY);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tm_qm_ctrl.md
TM_QM_CTRL -- requirements
Module: tm_qm_ctrl

Interface
REQ-001 SHALL have parameter QUEUE_ID_NBITS, default `FOURTH_LVL_QUEUE_ID_NBITS, queue index width.
REQ-002 SHALL have parameter QUEUE_ENTRIES_NBITS, default `FOURTH_LVL_QUEUE_ID_NBITS, buffer index width.
REQ-003 SHALL have clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have enq_req  in  1  level; held until enq_ack or enq_drop.
REQ-006 SHALL have enq_qid  in  QUEUE_ID_NBITS, and enq_desc  in  sch_pkt_desc_type; both stable while enq_req is high.
REQ-007 SHALL have enq_ack and enq_drop  out  1  each; one-cycle completion pulses.
REQ-008 SHALL have deq_req  in  1  level, and deq_qid  in  QUEUE_ID_NBITS; both held until deq_valid or deq_empty.
REQ-009 SHALL have deq_valid and deq_empty  out  1  each, pulses; deq_desc  out  sch_pkt_desc_type, qualified by deq_valid.
REQ-010 SHALL have init_done  out  1  high once memory initialisation is complete.
REQ-011 SHALL drive, for each of head, tail, depth, depth1, ll and pkt_desc: <m>_wr, <m>_raddr, <m>_waddr, <m>_wdata out; <m>_rdata in. Widths match the 1R1W queue memories; read data returns one cycle after raddr.

Function
REQ-012 SHALL run state INIT after reset: counter i over 0..2^QUEUE_ENTRIES_NBITS-1; writes ll[i]=i+1; for i<2^QUEUE_ID_NBITS, writes head/tail/depth/depth1[i]=0. On the last index SHALL set init_done=1 and go to IDLE.
REQ-013 SHALL keep free-list registers fl_head, fl_tail and fl_cnt (QUEUE_ENTRIES_NBITS+1 bits). Reset values: fl_head=0, fl_tail=2^N-2, fl_cnt=2^N-1. Entry 2^N-1 is reserved and never allocated.
REQ-014 SHALL ignore requests while init_done=0; no response is issued.
REQ-015 SHALL serve one operation at a time and return to IDLE after each one. When both requests are high in IDLE, SHALL serve the type not served last. The last-served flag resets to "deq", so enqueue goes first.
REQ-016 Enqueue SHALL take states E0, E1.
- E0: if fl_cnt==0, pulse enq_drop and go to IDLE. Otherwise read tail[qid], depth[qid] and ll[fl_head], and latch buf=fl_head.
- E1: write pkt_desc[buf]=enq_desc. If depth==0, write head[qid]=buf; otherwise write ll[tail]=buf. Write tail[qid]=buf and depth/depth1[qid]=depth+1. Set fl_head=ll_rdata, decrement fl_cnt, pulse enq_ack.
REQ-017 Enqueue latency SHALL be 2 cycles from IDLE sample to enq_ack.
REQ-018 Dequeue SHALL take states D0, D1, D2.
- D0: read head[qid] and depth[qid].
- D1: if depth==0, pulse deq_empty and go to IDLE. Otherwise read ll[head] and pkt_desc[head], and latch buf=head.
- D2: drive deq_desc=pkt_desc_rdata with a deq_valid pulse. Write head[qid]=ll_rdata and depth/depth1[qid]=depth-1. Tail is not written.
REQ-019 In D2, buf SHALL be appended to the free list. If fl_cnt==0, set fl_head=fl_tail=buf with no ll write. Otherwise write ll[fl_tail]=buf and set fl_tail=buf. Increment fl_cnt.
REQ-020 At most one write per memory per cycle; depth1 SHALL always be written with the same waddr/wdata as depth.
REQ-021 Depth arithmetic SHALL be QUEUE_ENTRIES_NBITS wide and cannot wrap, because allocation is bounded by fl_cnt.

Reset
REQ-022 Asserting rst at any time, including mid-operation, SHALL abort the operation with no response pulse, return to INIT and rerun initialisation.
REQ-023 All outputs SHALL reset to 0: acks, pulses, write enables, addresses, wdata, deq_desc and init_done.

Structure
REQ-024 sch_pkt_desc_type SHALL come from meta_package. The state enum and free-list reset constants SHALL stay local.
REQ-025 No sub-module. The memories SHALL be instantiated at the parent level and connected to the REQ-011 ports.

Verification (QUEUE_ID_NBITS=2, QUEUE_ENTRIES_NBITS=3)
REQ-026 Reset, then idle:
- init_done rises after 8 INIT cycles.
- all outputs stay 0 until then.
- enq_req held high during INIT receives no response.
REQ-027 Enqueue A, B to queue 1, then dequeue queue 1 twice:
- enq_ack 2 cycles after each sample.
- deq_desc returns A, then B, each 3 cycles after sample.
- a third dequeue gives deq_empty.
REQ-028 Enqueue 7 descriptors across queues 0-3:
- all 7 acked.
- the 8th gives enq_drop.
- after one dequeue, the next enqueue is acked and reuses the freed buffer index.
REQ-029 enq_req and deq_req held high together on queue 2 (non-empty):
- service alternates enq, deq, enq, ...
- enqueue is served first after reset.
REQ-030 Assert rst during D1:
- no deq_valid is issued.
- INIT reruns.
- a subsequent dequeue on any queue gives deq_empty.
